// File: rtl/vending_pkg.sv
// vending_pkg: shared coin, change and state encodings for the vending controller
package vending_pkg;
    typedef enum logic [1:0] {COIN_NONE, COIN_5, COIN_10, COIN_20} coin_t;
    typedef enum logic [1:0] {CHG_NONE, CHG_5, CHG_10} change_t;
    typedef enum logic [1:0] {IDLE, COLLECT, VEND, CHANGE} state_t;
    function automatic logic [4:0] coin_value(input coin_t c);
        return c == COIN_5 ? 5'd5 : c == COIN_10 ? 5'd10 : c == COIN_20 ? 5'd20 : 5'd0;
    endfunction
endpackage

// File: rtl/vending_stock_bank.sv
// vending_stock_bank: per-item stock counters with vend decrement, restock refill and sold_out flags
module vending_stock_bank
    import vending_pkg::*;
#(
    parameter int NUM_ITEMS = 4,
    parameter int MAX_STOCK = 7,
    localparam int IW = NUM_ITEMS > 1 ? $clog2(NUM_ITEMS) : 1,
    localparam int SW = $clog2(MAX_STOCK + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 dec,
    input  logic [IW-1:0]        dec_item,
    input  logic                 restock,
    input  logic [IW-1:0]        restock_item,
    output logic [NUM_ITEMS-1:0] sold_out
);
    logic [SW-1:0] stock [NUM_ITEMS];
    // restock takes precedence over a same-cycle vend of the same item
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_ITEMS; i++) begin
            if (rst || (restock && restock_item == IW'(i)))
                stock[i] <= SW'(MAX_STOCK);
            else if (dec && dec_item == IW'(i))
                stock[i] <= stock[i] - SW'(1);
        end
    end
    for (genvar g = 0; g < NUM_ITEMS; g++) begin : g_so
        assign sold_out[g] = stock[g] == '0;
    end
endmodule

// File: rtl/vending_machine_multi.sv
// vending_machine_multi: multi-product coin vending controller with credit, change, refund and restock
module vending_machine_multi
    import vending_pkg::*;
#(
    parameter int NUM_ITEMS = 4,
    parameter int CREDIT_W = 8,
    parameter int MAX_CREDIT = 100,
    parameter int MAX_STOCK = 7,
    parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES = {8'd20, 8'd15, 8'd10, 8'd5},
    localparam int IW = NUM_ITEMS > 1 ? $clog2(NUM_ITEMS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           a,
    input  logic                 sel_valid,
    input  logic [IW-1:0]        sel_item,
    input  logic                 cancel,
    input  logic                 restock,
    input  logic [IW-1:0]        restock_item,
    output logic                 b,
    output logic [IW-1:0]        vend_item,
    output logic [1:0]           change,
    output logic                 coin_reject,
    output logic                 sel_nack,
    output logic [CREDIT_W-1:0]  credit,
    output logic [NUM_ITEMS-1:0] sold_out,
    output logic                 busy
);
    state_t state, state_n;
    change_t chg;
    logic [CREDIT_W:0] coin_sum;
    logic [CREDIT_W-1:0] price, chg_val, credit_n;
    logic vend_ok, accept, drain;
    assign busy = state == VEND || state == CHANGE;
    always_comb begin
        price = PRICES[sel_item*CREDIT_W +: CREDIT_W];
        coin_sum = {1'b0, credit} + (CREDIT_W+1)'(coin_value(coin_t'(a)));
        chg = credit >= CREDIT_W'(10) ? CHG_10 : CHG_5;
        chg_val = chg == CHG_10 ? CREDIT_W'(10) : CREDIT_W'(5);
        vend_ok = !busy && !cancel && sel_valid && !sold_out[sel_item] && credit >= price;
        accept = !busy && !cancel && !sel_valid && coin_sum <= (CREDIT_W+1)'(MAX_CREDIT);
        // one change coin per cycle while busy, or on a refund request with credit
        drain = credit != '0 && (busy || cancel);
        credit_n = drain ? credit - chg_val : vend_ok ? credit - price : accept ? coin_sum[CREDIT_W-1:0] : credit;
        state_n = drain ? CHANGE : vend_ok ? VEND : (busy || credit_n == '0) ? IDLE : COLLECT;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            credit <= '0;
            b <= 1'b0;
            vend_item <= '0;
            change <= CHG_NONE;
            coin_reject <= 1'b0;
            sel_nack <= 1'b0;
        end else begin
            state <= state_n;
            credit <= credit_n;
            b <= vend_ok;
            if (vend_ok) vend_item <= sel_item;
            change <= drain ? chg : CHG_NONE;
            coin_reject <= a != 2'b00 && !accept;
            sel_nack <= sel_valid && !vend_ok && (busy || !cancel);
        end
    end
    vending_stock_bank #(.NUM_ITEMS(NUM_ITEMS), .MAX_STOCK(MAX_STOCK)) u_stock (
        .clk(clk),
        .rst(rst),
        .dec(vend_ok),
        .dec_item(sel_item),
        .restock(restock),
        .restock_item(restock_item),
        .sold_out(sold_out)
    );
endmodule

// File: tb/tb_vending_machine_multi.sv
// tb_vending_machine_multi: directed and random stimulus against a queue-based sales model
module tb_vending_machine_multi;
    localparam int N = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0] a = '0;
    logic sel_valid = 1'b0;
    logic [1:0] sel_item = '0;
    logic cancel = 1'b0;
    logic restock = 1'b0;
    logic [1:0] restock_item = '0;
    logic b, coin_reject, sel_nack, busy;
    logic [1:0] vend_item, change;
    logic [7:0] credit;
    logic [N-1:0] sold_out;
    int tests = 0;
    int fails = 0;
    int prices[N] = '{5, 10, 15, 20};
    int m_credit, m_cur, e_vi, e_chg;
    int m_stock[N];
    int m_q[$];
    bit e_b, e_rej, e_nack;
    int r_coin, r_si, r_ri;
    bit r_cn, r_sv, r_rs;

    vending_machine_multi dut (
        .clk(clk), .rst(rst), .a(a), .sel_valid(sel_valid), .sel_item(sel_item),
        .cancel(cancel), .restock(restock), .restock_item(restock_item),
        .b(b), .vend_item(vend_item), .change(change), .coin_reject(coin_reject),
        .sel_nack(sel_nack), .credit(credit), .sold_out(sold_out), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input int exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int so_exp();
        int v = 0;
        for (int i = 0; i < N; i++) if (m_stock[i] == 0) v |= 1 << i;
        return v;
    endfunction

    task automatic model_reset();
        m_credit = 0;
        m_cur = 0;
        e_vi = 0;
        e_chg = 0;
        e_b = 0;
        e_rej = 0;
        e_nack = 0;
        m_q.delete();
        for (int i = 0; i < N; i++) m_stock[i] = 7;
    endtask

    // pending change is the greedy list of 10s then one 5
    task automatic refund(input int c);
        m_q.delete();
        while (c >= 10) begin
            m_q.push_back(10);
            c -= 10;
        end
        if (c == 5) m_q.push_back(5);
    endtask

    // m_cur: 0 = not busy, -1 = vending this cycle, 5/10 = change coin this cycle
    task automatic predict(input int coin, input bit sv, input int si, input bit cn, input bit rs, input int ri);
        int v;
        v = coin == 1 ? 5 : coin == 2 ? 10 : coin == 3 ? 20 : 0;
        e_b = 0;
        e_rej = 0;
        e_nack = 0;
        e_chg = 0;
        if (m_cur != 0) begin
            e_rej = v != 0;
            e_nack = sv;
            m_cur = m_q.size() > 0 ? m_q.pop_front() : 0;
        end else if (cn) begin
            e_rej = v != 0;
            if (m_credit > 0) begin
                refund(m_credit);
                m_cur = m_q.pop_front();
            end
        end else if (sv) begin
            e_rej = v != 0;
            if (m_stock[si] > 0 && m_credit >= prices[si]) begin
                m_credit -= prices[si];
                m_stock[si]--;
                e_vi = si;
                refund(m_credit);
                m_cur = -1;
            end else e_nack = 1;
        end else if (m_credit + v <= 100) m_credit += v;
        else e_rej = 1;
        if (m_cur > 0) begin
            m_credit -= m_cur;
            e_chg = m_cur == 10 ? 2 : 1;
        end
        e_b = m_cur == -1;
        if (rs) m_stock[ri] = 7;
    endtask

    task automatic compare_all();
        check("credit", credit, m_credit);
        check("b", b, int'(e_b));
        if (e_b) check("vend_item", vend_item, e_vi);
        check("change", change, e_chg);
        check("coin_reject", coin_reject, int'(e_rej));
        check("sel_nack", sel_nack, int'(e_nack));
        check("busy", busy, int'(m_cur != 0));
        check("sold_out", sold_out, so_exp());
    endtask

    task automatic step(input int coin, input bit sv, input int si, input bit cn, input bit rs, input int ri);
        a = 2'(coin);
        sel_valid = sv;
        sel_item = 2'(si);
        cancel = cn;
        restock = rs;
        restock_item = 2'(ri);
        predict(coin, sv, si, cn, rs, ri);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        a = '0;
        sel_valid = 1'b0;
        cancel = 1'b0;
        restock = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        compare_all();
        check("vend_item_rst", vend_item, 0);
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        model_reset();
        do_reset(2);
        step(1, 0, 0, 0, 0, 0);
        step(2, 0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0);
        idle(2);
        step(3, 0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0);
        idle(3);
        step(2, 0, 0, 0, 0, 0);
        step(2, 0, 0, 0, 0, 0);
        step(2, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        idle(5);
        step(2, 0, 0, 0, 0, 0);
        step(0, 1, 3, 0, 0, 0);
        step(1, 1, 2, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        idle(3);
        for (int i = 0; i < 7; i++) begin
            step(1, 0, 0, 0, 0, 0);
            step(0, 1, 0, 0, 0, 0);
            idle(1);
        end
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        step(0, 1, 0, 0, 0, 0);
        idle(2);
        repeat (5) step(3, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(2, 1, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(3, 1, 2, 0, 0, 0);
        idle(1);
        do_reset(1);
        idle(2);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) do_reset(1);
            else begin
                r_coin = $urandom_range(0, 3);
                if ($urandom_range(0, 2) == 0) r_coin = 0;
                r_cn = $urandom_range(0, 24) == 0;
                r_sv = !r_cn && $urandom_range(0, 4) == 0;
                r_si = $urandom_range(0, N - 1);
                r_rs = $urandom_range(0, 39) == 0;
                r_ri = $urandom_range(0, N - 1);
                step(r_coin, r_sv, r_si, r_cn, r_rs, r_ri);
            end
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
